// File: rtl/alarm_ctrl.sv
// -----------------------------------------------------------------------------
// alarm_ctrl
//   Compares the current time against the stored alarm time and runs the
//   ring / snooze / stop state machine that drives the buzzer.
//
// Ports:
//   CLK          system clock
//   RESETN       synchronous, active-low reset
//   CUR_TIME     current time {MERIDIAN, HOUR[3:0], MIN[5:0], SEC[5:0]}
//   ALARM_TIME   alarm time, same layout (MERIDIAN is not compared)
//   ALARM_EN     alarm armed (level); low forces IDLE and blocks triggers
//   SEC_TICK     one-cycle pulse per second
//   STOP_BTN     one-cycle stop pulse
//   SNOOZE_BTN   one-cycle snooze pulse
//   ALARM_RING   buzzer enable
//   RING_START   one-cycle pulse in the cycle after every entry to RING
//   ALARM_STATE  00 IDLE, 01 RING, 10 SNOOZE
//   SNOOZE_CNT   snoozes used in the current alarm event
// -----------------------------------------------------------------------------
module alarm_ctrl #(
  parameter int RING_SECS   = 60,
  parameter int SNOOZE_SECS = 300,
  parameter int MAX_SNOOZE  = 3
) (
  input  logic        CLK,
  input  logic        RESETN,
  input  logic [16:0] CUR_TIME,
  input  logic [16:0] ALARM_TIME,
  input  logic        ALARM_EN,
  input  logic        SEC_TICK,
  input  logic        STOP_BTN,
  input  logic        SNOOZE_BTN,
  output logic        ALARM_RING,
  output logic        RING_START,
  output logic [1:0]  ALARM_STATE,
  output logic [2:0]  SNOOZE_CNT
);

  localparam logic [1:0] ST_IDLE   = 2'b00;
  localparam logic [1:0] ST_RING   = 2'b01;
  localparam logic [1:0] ST_SNOOZE = 2'b10;

  localparam logic [8:0] RING_LIMIT  = 9'(RING_SECS);
  localparam logic [8:0] SNOOZE_LOAD = 9'(SNOOZE_SECS);
  localparam logic [2:0] SNOOZE_MAX  = 3'(MAX_SNOOZE);

  logic [1:0] state_r;
  logic [1:0] state_nxt_s;
  logic [8:0] timer_r;
  logic [8:0] timer_nxt_s;
  logic [8:0] timer_inc_s;
  logic [2:0] snooze_cnt_r;
  logic [2:0] snooze_cnt_nxt_s;
  logic       match_s;
  logic       match_d_r;
  logic       trigger_s;
  logic       ring_start_nxt_s;
  logic       ring_start_r;
  logic       alarm_ring_r;
  logic       unused_meridian_s;

  // MERIDIAN does not take part in the comparison.
  assign match_s           = (CUR_TIME[15:0] == ALARM_TIME[15:0]);
  assign unused_meridian_s = CUR_TIME[16] ^ ALARM_TIME[16];
  // Only the rising edge of the match triggers, so a held time cannot retrigger.
  assign trigger_s         = match_s & ~match_d_r;
  assign timer_inc_s       = timer_r + 9'd1;

  // Next-state, timer and snooze-count selection in priority order.
  always_comb begin
    state_nxt_s      = state_r;
    timer_nxt_s      = timer_r;
    snooze_cnt_nxt_s = snooze_cnt_r;
    ring_start_nxt_s = 1'b0;
    if (!ALARM_EN) begin
      state_nxt_s      = ST_IDLE;
      timer_nxt_s      = 9'd0;
      snooze_cnt_nxt_s = 3'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (trigger_s) begin
            state_nxt_s      = ST_RING;
            timer_nxt_s      = 9'd0;
            ring_start_nxt_s = 1'b1;
          end else begin
            timer_nxt_s      = 9'd0;
          end
        end
        ST_RING: begin
          if (STOP_BTN) begin
            state_nxt_s      = ST_IDLE;
            timer_nxt_s      = 9'd0;
            snooze_cnt_nxt_s = 3'd0;
          end else if (SEC_TICK && (timer_inc_s == RING_LIMIT)) begin
            // Auto-stop: the increment on this tick reaches the ring length.
            state_nxt_s      = ST_IDLE;
            timer_nxt_s      = 9'd0;
            snooze_cnt_nxt_s = 3'd0;
          end else if (SNOOZE_BTN && (snooze_cnt_r < SNOOZE_MAX)) begin
            state_nxt_s      = ST_SNOOZE;
            timer_nxt_s      = SNOOZE_LOAD;
            snooze_cnt_nxt_s = snooze_cnt_r + 3'd1;
          end else if (SEC_TICK) begin
            timer_nxt_s      = timer_inc_s;
          end else begin
            timer_nxt_s      = timer_r;
          end
        end
        ST_SNOOZE: begin
          if (STOP_BTN) begin
            state_nxt_s      = ST_IDLE;
            timer_nxt_s      = 9'd0;
            snooze_cnt_nxt_s = 3'd0;
          end else if (SEC_TICK) begin
            // A zero timer here is unreachable; treating it like 1 avoids a wrap.
            if (timer_r <= 9'd1) begin
              state_nxt_s      = ST_RING;
              timer_nxt_s      = 9'd0;
              ring_start_nxt_s = 1'b1;
            end else begin
              timer_nxt_s      = timer_r - 9'd1;
            end
          end else begin
            timer_nxt_s      = timer_r;
          end
        end
        default: begin
          state_nxt_s      = ST_IDLE;
          timer_nxt_s      = 9'd0;
          snooze_cnt_nxt_s = 3'd0;
        end
      endcase
    end
  end

  // State, timer, counters and registered outputs.
  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      state_r      <= ST_IDLE;
      timer_r      <= 9'd0;
      snooze_cnt_r <= 3'd0;
      match_d_r    <= 1'b0;
      ring_start_r <= 1'b0;
      alarm_ring_r <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      timer_r      <= timer_nxt_s;
      snooze_cnt_r <= snooze_cnt_nxt_s;
      match_d_r    <= match_s;
      ring_start_r <= ring_start_nxt_s;
      alarm_ring_r <= (state_nxt_s == ST_RING);
    end
  end

  assign ALARM_RING  = alarm_ring_r;
  assign RING_START  = ring_start_r;
  assign ALARM_STATE = state_r;
  assign SNOOZE_CNT  = snooze_cnt_r;

endmodule

// File: tb/tb_alarm_ctrl.sv
module tb_alarm_ctrl;

  localparam int RING_S   = 5;
  localparam int SNOOZE_S = 3;
  localparam int MAX_SNZ  = 2;

  logic        CLK;
  logic        RESETN;
  logic [16:0] CUR_TIME;
  logic [16:0] ALARM_TIME;
  logic        ALARM_EN;
  logic        SEC_TICK;
  logic        STOP_BTN;
  logic        SNOOZE_BTN;
  logic        ALARM_RING;
  logic        RING_START;
  logic [1:0]  ALARM_STATE;
  logic [2:0]  SNOOZE_CNT;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  alarm_ctrl #(.RING_SECS(RING_S), .SNOOZE_SECS(SNOOZE_S), .MAX_SNOOZE(MAX_SNZ)) dut (
    .CLK(CLK), .RESETN(RESETN), .CUR_TIME(CUR_TIME), .ALARM_TIME(ALARM_TIME),
    .ALARM_EN(ALARM_EN), .SEC_TICK(SEC_TICK), .STOP_BTN(STOP_BTN),
    .SNOOZE_BTN(SNOOZE_BTN), .ALARM_RING(ALARM_RING), .RING_START(RING_START),
    .ALARM_STATE(ALARM_STATE), .SNOOZE_CNT(SNOOZE_CNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // One-second tick: one cycle high in every 100 clocks.
  initial begin
    SEC_TICK = 1'b0;
    forever begin
      repeat (99) @(posedge CLK);
      #1 SEC_TICK = 1'b1;
      @(posedge CLK);
      #1 SEC_TICK = 1'b0;
    end
  end

  function automatic logic [16:0] tm(input bit mer, input int h, input int m, input int s);
    return {mer, 4'(h), 6'(m), 6'(s)};
  endfunction

  // Reference model: the alarm described as "is it ringing / snoozing",
  // seconds rung so far, seconds of snooze remaining and snoozes used.
  typedef struct packed {
    bit ringing;
    bit snoozing;
    int rung;
    int left;
    int snoozes;
    bit start;
    bit prev_match;
  } model_t;

  model_t mdl;

  function automatic model_t next_model(input model_t m, input bit rstn, input bit en,
                                        input logic [16:0] cur, input logic [16:0] alm,
                                        input bit tick, input bit stop, input bit snz);
    model_t n;
    bit     match;
    n       = m;
    n.start = 1'b0;
    match   = (cur[15:0] == alm[15:0]);
    n.prev_match = match;
    if (!rstn) begin
      n = '0;
    end else if (!en) begin
      n.ringing = 1'b0; n.snoozing = 1'b0; n.rung = 0; n.left = 0; n.snoozes = 0;
    end else if (m.ringing) begin
      if (stop || (tick && (m.rung + 1 >= RING_S))) begin
        n.ringing = 1'b0; n.rung = 0; n.snoozes = 0;
      end else if (snz && (m.snoozes < MAX_SNZ)) begin
        n.ringing = 1'b0; n.snoozing = 1'b1; n.left = SNOOZE_S; n.snoozes = m.snoozes + 1;
      end else if (tick) begin
        n.rung = m.rung + 1;
      end
    end else if (m.snoozing) begin
      if (stop) begin
        n.snoozing = 1'b0; n.left = 0; n.snoozes = 0;
      end else if (tick) begin
        n.left = m.left - 1;
        if (n.left == 0) begin
          n.snoozing = 1'b0; n.ringing = 1'b1; n.rung = 0; n.start = 1'b1;
        end
      end
    end else if (match && !m.prev_match) begin
      n.ringing = 1'b1; n.rung = 0; n.start = 1'b1;
    end
    return n;
  endfunction

  always @(posedge CLK)
    mdl <= next_model(mdl, RESETN, ALARM_EN, CUR_TIME, ALARM_TIME, SEC_TICK, STOP_BTN, SNOOZE_BTN);

  // Advance one clock; reports whether a second tick was sampled at that edge.
  task automatic step(output bit ticked);
    ticked = SEC_TICK;
    @(posedge CLK);
    #2;
  endtask

  task automatic enter_ring();
    bit t;
    CUR_TIME = tm(1'b0, 7, 29, 59);
    step(t);
    step(t);
    CUR_TIME = tm(1'b0, 7, 30, 0);
    step(t);
  endtask

  task automatic test_reset();
    bit t;
    RESETN = 1'b0;
    repeat (3) step(t);
    chk_cnt++;
    if ({ALARM_STATE, ALARM_RING, RING_START, SNOOZE_CNT} !== 7'd0)
      $display("FAIL reset_state: got state=%b ring=%b start=%b cnt=%0d, want all zero",
               ALARM_STATE, ALARM_RING, RING_START, SNOOZE_CNT);
    else pass_cnt++;
    RESETN = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step(t);
      chk_cnt++;
      if ({ALARM_STATE, ALARM_RING, RING_START, SNOOZE_CNT} !== 7'd0)
        $display("FAIL idle_disabled cyc %0d: got state=%b ring=%b start=%b cnt=%0d, want all zero",
                 i, ALARM_STATE, ALARM_RING, RING_START, SNOOZE_CNT);
      else pass_cnt++;
    end
  endtask

  task automatic test_trigger_autostop();
    bit t;
    int ticks, starts, n;
    ALARM_EN = 1'b1;
    enter_ring();
    chk_cnt++;
    if ({ALARM_STATE, ALARM_RING, RING_START} !== 4'b0111)
      $display("FAIL trigger_entry: got state=%b ring=%b start=%b, want 01 1 1",
               ALARM_STATE, ALARM_RING, RING_START);
    else pass_cnt++;
    starts = int'(RING_START);
    ticks = 0; n = 0;
    while (ALARM_STATE == 2'b01 && n < 800) begin
      step(t);
      if (t) ticks++;
      if (RING_START) starts++;
      n++;
      if (n == 99) CUR_TIME = tm(1'b0, 7, 30, 1);
    end
    chk_cnt++;
    if (starts !== 1)
      $display("FAIL single_trigger: got %0d RING_START pulses, want 1", starts);
    else pass_cnt++;
    chk_cnt++;
    if (ticks !== RING_S || ALARM_STATE !== 2'b00 || ALARM_RING !== 1'b0)
      $display("FAIL auto_stop: got stop after %0d ticks state=%b ring=%b, want %0d ticks 00 0",
               ticks, ALARM_STATE, ALARM_RING, RING_S);
    else pass_cnt++;
  endtask

  task automatic wait_snooze_expiry(input string name, input logic [2:0] cnt_exp);
    bit t;
    int ticks, n;
    ticks = 0; n = 0;
    while (ALARM_STATE == 2'b10 && n < 600) begin
      step(t);
      if (t) ticks++;
      n++;
    end
    chk_cnt++;
    if (ticks !== SNOOZE_S || ALARM_STATE !== 2'b01 || RING_START !== 1'b1 || SNOOZE_CNT !== cnt_exp)
      $display("FAIL %s: got ticks=%0d state=%b start=%b cnt=%0d, want %0d 01 1 %0d",
               name, ticks, ALARM_STATE, RING_START, SNOOZE_CNT, SNOOZE_S, cnt_exp);
    else pass_cnt++;
  endtask

  task automatic test_snooze();
    bit t;
    enter_ring();
    step(t);
    SNOOZE_BTN = 1'b1; step(t); SNOOZE_BTN = 1'b0;
    chk_cnt++;
    if (ALARM_STATE !== 2'b10 || SNOOZE_CNT !== 3'd1 || ALARM_RING !== 1'b0)
      $display("FAIL snooze1: got state=%b cnt=%0d ring=%b, want 10 1 0", ALARM_STATE, SNOOZE_CNT, ALARM_RING);
    else pass_cnt++;
    wait_snooze_expiry("snooze1_expiry", 3'd1);
    step(t);
    SNOOZE_BTN = 1'b1; step(t); SNOOZE_BTN = 1'b0;
    chk_cnt++;
    if (ALARM_STATE !== 2'b10 || SNOOZE_CNT !== 3'd2)
      $display("FAIL snooze2: got state=%b cnt=%0d, want 10 2", ALARM_STATE, SNOOZE_CNT);
    else pass_cnt++;
    wait_snooze_expiry("snooze2_expiry", 3'd2);
    step(t);
    SNOOZE_BTN = 1'b1; step(t); SNOOZE_BTN = 1'b0;
    chk_cnt++;
    if (ALARM_STATE !== 2'b01 || SNOOZE_CNT !== 3'd2 || ALARM_RING !== 1'b1)
      $display("FAIL snooze_limit: got state=%b cnt=%0d ring=%b, want 01 2 1", ALARM_STATE, SNOOZE_CNT, ALARM_RING);
    else pass_cnt++;
  endtask

  task automatic test_stop_priority();
    bit t;
    STOP_BTN = 1'b1; SNOOZE_BTN = 1'b1;
    step(t);
    STOP_BTN = 1'b0; SNOOZE_BTN = 1'b0;
    chk_cnt++;
    if (ALARM_STATE !== 2'b00 || SNOOZE_CNT !== 3'd0 || ALARM_RING !== 1'b0)
      $display("FAIL stop_priority: got state=%b cnt=%0d ring=%b, want 00 0 0", ALARM_STATE, SNOOZE_CNT, ALARM_RING);
    else pass_cnt++;
  endtask

  task automatic test_disable_snooze();
    bit t;
    bit left_idle;
    enter_ring();
    step(t);
    SNOOZE_BTN = 1'b1; step(t); SNOOZE_BTN = 1'b0;
    chk_cnt++;
    if (ALARM_STATE !== 2'b10 || SNOOZE_CNT !== 3'd1)
      $display("FAIL disable_pre: got state=%b cnt=%0d, want 10 1", ALARM_STATE, SNOOZE_CNT);
    else pass_cnt++;
    ALARM_EN = 1'b0;
    step(t);
    chk_cnt++;
    if (ALARM_STATE !== 2'b00 || SNOOZE_CNT !== 3'd0 || ALARM_RING !== 1'b0)
      $display("FAIL disable_idle: got state=%b cnt=%0d ring=%b, want 00 0 0", ALARM_STATE, SNOOZE_CNT, ALARM_RING);
    else pass_cnt++;
    repeat (5) step(t);
    ALARM_EN = 1'b1;
    left_idle = 1'b0;
    for (int i = 0; i < 350; i++) begin
      step(t);
      if (ALARM_STATE !== 2'b00 || ALARM_RING !== 1'b0) left_idle = 1'b1;
    end
    chk_cnt++;
    if (left_idle !== 1'b0)
      $display("FAIL reenable_no_edge: got left IDLE=%b, want 0", left_idle);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_ring();
    bit t;
    int ticks, n;
    enter_ring();
    ticks = 0; n = 0;
    while (ticks < 2 && n < 400) begin
      step(t);
      if (t) ticks++;
      n++;
    end
    chk_cnt++;
    if (ALARM_STATE !== 2'b01)
      $display("FAIL mid_ring_pre: got state=%b, want 01", ALARM_STATE);
    else pass_cnt++;
    RESETN = 1'b0;
    CUR_TIME = tm(1'b0, 7, 29, 59);
    step(t);
    RESETN = 1'b1;
    chk_cnt++;
    if ({ALARM_STATE, ALARM_RING, RING_START, SNOOZE_CNT} !== 7'd0)
      $display("FAIL mid_ring_reset: got state=%b ring=%b start=%b cnt=%0d, want all zero",
               ALARM_STATE, ALARM_RING, RING_START, SNOOZE_CNT);
    else pass_cnt++;
    step(t);
    CUR_TIME = tm(1'b0, 7, 30, 0);
    step(t);
    chk_cnt++;
    if (ALARM_STATE !== 2'b01 || RING_START !== 1'b1)
      $display("FAIL fresh_trigger: got state=%b start=%b, want 01 1", ALARM_STATE, RING_START);
    else pass_cnt++;
    ticks = 0; n = 0;
    while (ALARM_STATE == 2'b01 && n < 800) begin
      step(t);
      if (t) ticks++;
      n++;
    end
    chk_cnt++;
    if (ticks !== RING_S || ALARM_STATE !== 2'b00)
      $display("FAIL fresh_full_ring: got stop after %0d ticks state=%b, want %0d ticks 00",
               ticks, ALARM_STATE, RING_S);
    else pass_cnt++;
  endtask

  task automatic test_random();
    bit         t;
    logic [1:0] exp_state;
    for (int i = 0; i < 6000; i++) begin
      ALARM_EN   = ($urandom_range(0, 199) != 0);
      STOP_BTN   = ($urandom_range(0, 299) == 0);
      SNOOZE_BTN = ($urandom_range(0, 59) == 0);
      RESETN     = ($urandom_range(0, 1499) != 0);
      if ($urandom_range(0, 19) == 0) begin
        case ($urandom_range(0, 3))
          0: CUR_TIME = tm(1'b0, 7, 30, 0);
          1: CUR_TIME = tm(1'b1, 7, 30, 0);
          2: CUR_TIME = tm(1'b0, 7, 30, 1);
          default: CUR_TIME = tm(1'b0, 7, 29, 59);
        endcase
      end
      step(t);
      exp_state = mdl.snoozing ? 2'b10 : (mdl.ringing ? 2'b01 : 2'b00);
      chk_cnt++;
      if ({ALARM_STATE, ALARM_RING, RING_START, SNOOZE_CNT} !==
          {exp_state, mdl.ringing, mdl.start, 3'(mdl.snoozes)})
        $display("FAIL random cyc %0d: got state=%b ring=%b start=%b cnt=%0d, want %b %b %b %0d",
                 i, ALARM_STATE, ALARM_RING, RING_START, SNOOZE_CNT,
                 exp_state, mdl.ringing, mdl.start, mdl.snoozes);
      else pass_cnt++;
    end
    STOP_BTN = 1'b0; SNOOZE_BTN = 1'b0; RESETN = 1'b1;
  endtask

  initial begin
    bit t;
    RESETN     = 1'b0;
    CUR_TIME   = tm(1'b0, 7, 30, 0);
    ALARM_TIME = tm(1'b0, 7, 30, 0);
    ALARM_EN   = 1'b0;
    STOP_BTN   = 1'b0;
    SNOOZE_BTN = 1'b0;
    @(posedge CLK);
    #2;
    test_reset();
    test_trigger_autostop();
    test_snooze();
    test_stop_priority();
    test_disable_snooze();
    test_reset_mid_ring();
    test_random();
    step(t);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
